// File: rtl/srambank_pkg.sv
// Shared types for the SRAM bank request front-end.
// Word/address widths match the 256x4x36 bank macro.
package srambank_pkg;
  localparam int SRAMBANK_ADDR_W = 10;
  localparam int SRAMBANK_DATA_W = 36;

  typedef logic [SRAMBANK_ADDR_W-1:0] srambank_addr_t;
  typedef logic [SRAMBANK_DATA_W-1:0] srambank_word_t;

  typedef struct packed {
    logic           write;
    srambank_addr_t addr;
    srambank_word_t wdata;
  } srambank_req_t;
endpackage

// File: rtl/srambank_req_ctrl_if.sv
// Client request/response channels plus the bank strobe bus.
// slave = controller side, master = client/bank environment side.
interface srambank_req_ctrl_if
  import srambank_pkg::*;
#(
  parameter int ADDR_W = SRAMBANK_ADDR_W,
  parameter int DATA_W = SRAMBANK_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] wd;
  logic              banksel;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] dataout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  rsp_ready, dataout,
    output req_ready, rsp_valid, rsp_data,
    output ADDRESS, wd, banksel, read, write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output rsp_ready, dataout,
    input  req_ready, rsp_valid, rsp_data,
    input  ADDRESS, wd, banksel, read, write
  );
endinterface

// File: rtl/srambank_rsp_fifo.sv
// Small response FIFO; entries are not reset, only pointers/occupancy.
module srambank_rsp_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 36
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          din_i,
  output logic [$clog2(DEPTH+1)-1:0] occ_o,
  output logic [DATA_W-1:0]          head_o
);
  localparam int OW    = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q + OW'(push_i) - OW'(pop_i);
    if (push_i) wr_ptr_d = nxt(wr_ptr_q);
    if (pop_i)  rd_ptr_d = nxt(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];
endmodule

// File: rtl/srambank_req_ctrl.sv
// Valid/ready front-end for one SRAM bank: strobes, read tracking,
// and credit-gated response FIFO so no read data is ever dropped.
module srambank_req_ctrl
  import srambank_pkg::*;
#(
  parameter int ADDR_W    = SRAMBANK_ADDR_W,
  parameter int DATA_W    = SRAMBANK_DATA_W,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  srambank_req_ctrl_if.slave bus
);
  localparam int OW = $clog2(RSP_DEPTH+1);
  localparam int PW = OW + 1;

  srambank_req_t req;
  logic          fire;
  logic          pop;
  logic          credit_ok;
  logic          rd_inflight_q, rd_inflight_d;
  logic [OW-1:0] occ;
  logic [PW-1:0] pend;

  assign req = '{
    write: bus.req_write,
    addr:  srambank_addr_t'(bus.req_addr),
    wdata: srambank_word_t'(bus.req_wdata)
  };

  // Slots already claimed after this cycle's pop; an inflight read owns one.
  assign pop       = bus.rsp_valid & bus.rsp_ready;
  assign pend      = {1'b0, occ} + PW'(rd_inflight_q) - PW'(pop);
  assign credit_ok = pend < PW'(RSP_DEPTH);

  assign bus.req_ready = ~reset & (req.write | credit_ok);
  assign fire          = bus.req_valid & bus.req_ready;

  assign bus.banksel = fire;
  assign bus.write   = fire & req.write;
  assign bus.read    = fire & ~req.write;
  assign bus.ADDRESS = ADDR_W'(req.addr);
  assign bus.wd      = DATA_W'(req.wdata);

  assign rd_inflight_d = bus.read;

  always_ff @(posedge clk) begin
    if (reset) rd_inflight_q <= 1'b0;
    else       rd_inflight_q <= rd_inflight_d;
  end

  srambank_rsp_fifo #(
    .DEPTH  (RSP_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (rd_inflight_q),
    .pop_i  (pop),
    .din_i  (bus.dataout),
    .occ_o  (occ),
    .head_o (bus.rsp_data)
  );

  assign bus.rsp_valid = (occ != '0);
endmodule
